// File: rtl/cipher_cfg_pkg.sv
// Shared types and chain layout for the cipher configuration loader.
// Bit offsets are positions within the serial configuration frame.
package cipher_cfg_pkg;

    localparam int CFG_W_DEFAULT = 195;

    localparam int K_MUX_BIT     = 194;
    localparam int A_MUX_BIT     = 193;
    localparam int D_EN_BIT      = 192;
    localparam int TX_TAPS_LSB   = 144;
    localparam int TX_STATE_LSB  = 96;
    localparam int RX_TAPS_LSB   = 48;
    localparam int RX_STATE_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_e;

endpackage

// File: rtl/cfg_piso_sipo.sv
// Rotating parallel-in/serial-out register plus a serial-in shadow that is
// copied to the parallel output only on commit, so partial passes never show.
module cfg_piso_sipo #(
    parameter int W = 195
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_dat,
    input  logic         i_shift,
    input  logic         i_commit,
    input  logic         i_ser,
    output logic         o_ser,
    output logic [W-1:0] o_par
);

    logic [W-1:0] r_sreg;
    logic [W-1:0] r_shadow;
    logic [W-1:0] r_par;
    logic [W-1:0] w_shadow_nxt;

    assign w_shadow_nxt = {i_ser, r_shadow[W-1:1]};

    // Rotation rather than a plain shift keeps the frame intact for a second pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg   <= '0;
            r_shadow <= '0;
            r_par    <= '0;
        end else begin
            if (i_load) begin
                r_sreg <= i_load_dat;
            end else if (i_shift) begin
                r_sreg <= {r_sreg[0], r_sreg[W-1:1]};
            end
            if (i_shift) begin
                r_shadow <= w_shadow_nxt;
            end
            if (i_commit) begin
                r_par <= w_shadow_nxt;
            end
        end
    end

    assign o_ser = r_sreg[0];
    assign o_par = r_par;

endmodule

// File: rtl/cipher_cfg_loader.sv
// Serial config-chain loader: shifts a frame LSB-first into the cipher and captures the old chain.
// Optional second verify pass with CIPHER_CFG_LOADER_VERIFY_EN.
module cipher_cfg_loader
    import cipher_cfg_pkg::*;
#(
    parameter int CFG_W      = CFG_W_DEFAULT,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CFG_W-1:0] frame,
    output logic             cfg_en,
    output logic             cfg_i,
    input  logic             cfg_o,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CFG_W-1:0] readback
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
   ,output logic             verify_err
`endif
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CFG_W - 1);
    // The bit counter doubles as the gap counter, so GAP_CYCLES must not exceed CFG_W.
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam cfg_state_e ST_AFTER_PASS = (GAP_CYCLES == 0) ? ST_DONE : ST_GAP;

    cfg_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cfg_en;
    logic              r_cfg_i;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
    logic              r_verr_acc;
    logic              r_verify_err;
`endif

    logic              w_accept;
    logic              w_abort;
    logic              w_pass_end;
    logic              w_commit;
    logic              w_ser;
    logic [CFG_W-1:0]  w_load_dat;
    logic [CFG_W-1:0]  w_readback;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_abort    = abort && (r_state inside {ST_SHIFT, ST_VERIFY, ST_GAP});
    assign w_pass_end = (r_cnt == BIT_LAST);
    assign w_commit   = (r_state == ST_SHIFT) && w_pass_end && !w_abort;
    // frame[0] goes straight to cfg_i, so the shifter starts one bit ahead.
    assign w_load_dat = {frame[0], frame[CFG_W-1:1]};

    cfg_piso_sipo #(.W(CFG_W)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_dat (w_load_dat),
        .i_shift    (r_cfg_en),
        .i_commit   (w_commit),
        .i_ser      (cfg_o),
        .o_ser      (w_ser),
        .o_par      (w_readback)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cfg_en     <= 1'b0;
            r_cfg_i      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
            r_verr_acc   <= 1'b0;
            r_verify_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_cfg_en  <= 1'b0;
                r_cfg_i   <= 1'b0;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state      <= ST_SHIFT;
                            r_cnt        <= '0;
                            r_cfg_en     <= 1'b1;
                            r_cfg_i      <= frame[0];
                            r_busy       <= 1'b1;
                            r_aborted    <= 1'b0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                            r_verr_acc   <= 1'b0;
                            r_verify_err <= 1'b0;
`endif
                        end
                    end
                    ST_SHIFT: begin
                        if (w_pass_end) begin
                            r_cnt <= '0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                            r_state <= ST_VERIFY;
                            r_cfg_i <= w_ser;
`else
                            r_state  <= ST_AFTER_PASS;
                            r_cfg_en <= 1'b0;
                            r_cfg_i  <= 1'b0;
`endif
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_cfg_i <= w_ser;
                        end
                    end
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                    ST_VERIFY: begin
                        // A healthy chain echoes the bit being driven now, one pass later.
                        r_verr_acc <= r_verr_acc | (cfg_o ^ r_cfg_i);
                        if (w_pass_end) begin
                            r_cnt    <= '0;
                            r_state  <= ST_AFTER_PASS;
                            r_cfg_en <= 1'b0;
                            r_cfg_i  <= 1'b0;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_cfg_i <= w_ser;
                        end
                    end
`endif
                    ST_GAP: begin
                        if (r_cnt == GAP_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
                        r_verify_err <= r_verr_acc;
`endif
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_en   = r_cfg_en;
    assign cfg_i    = r_cfg_i;
    assign busy     = r_busy;
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign readback = w_readback;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
    assign verify_err = r_verify_err;
`endif

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// Bench for cipher_cfg_loader: behavioural cipher chain, timeline model, per-cycle compare.
`timescale 1ns/1ps
module tb_cipher_cfg_loader;

    localparam int W   = 195;
    localparam int GAP = 4;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
    localparam int P = 2;
`else
    localparam int P = 1;
`endif
    localparam int LAT  = 1 + P*W + GAP + 1;
    localparam int LAT0 = 1 + P*W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] frame = '0;
    logic         cfg_en, cfg_i, cfg_o, busy, done, aborted;
    logic [W-1:0] readback;
    logic         start0 = 1'b0;
    logic         cfg_en0, cfg_i0, cfg_o0, busy0, done0, aborted0;
    logic [W-1:0] readback0;
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
    logic         verify_err, verify_err0;
`endif

    always #5 clk = ~clk;

    cipher_cfg_loader #(.CFG_W(W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .frame(frame),
        .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o), .busy(busy), .done(done),
        .aborted(aborted), .readback(readback)
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
       ,.verify_err(verify_err)
`endif
    );

    cipher_cfg_loader #(.CFG_W(W), .GAP_CYCLES(0)) dut_gap0 (
        .clk(clk), .rst(rst), .start(start0), .abort(1'b0), .frame(frame),
        .cfg_en(cfg_en0), .cfg_i(cfg_i0), .cfg_o(cfg_o0), .busy(busy0), .done(done0),
        .aborted(aborted0), .readback(readback0)
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
       ,.verify_err(verify_err0)
`endif
    );

    // Cipher chain: shifts toward bit 0 while enabled, bit 0 is the serial output.
    logic [W-1:0] chain  = '1;
    logic [W-1:0] chain0 = '1;
    int           en_run = 0;
    logic         flip7  = 1'b0;
    logic         flip_r = 1'b0;

    always @(posedge clk) begin
        if (cfg_en) chain <= {cfg_i, chain[W-1:1]};
        if (cfg_en0) chain0 <= {cfg_i0, chain0[W-1:1]};
        en_run <= cfg_en ? en_run + 1 : 0;
        flip_r <= flip7 && cfg_en && (en_run + 1 == W + 7);
    end
    assign cfg_o  = chain[0] ^ flip_r;
    assign cfg_o0 = chain0[0];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_frame();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    // Timeline model: everything follows from the accepted-start cycle m_t0.
    int           cyc = 0;
    int           m_t0 = 0;
    bit           m_act = 0;
    bit           m_abd = 0;
    bit           m_verr_acc = 0;
    bit           m_verr = 0;
    logic [W-1:0] m_frame = '0;
    logic [W-1:0] m_prev = '0;
    logic [W-1:0] m_rb = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 0; m_abd = 0; m_rb = '0; m_verr = 0; m_verr_acc = 0;
        end else begin
            int r;
            bit idle;
            r = cyc - m_t0;
            idle = !m_act || (r == LAT);
            if (m_act) begin
                if (abort && r >= 1 && r <= P*W + GAP) begin
                    m_act = 0;
                    m_abd = 1;
                end else begin
                    if (r == W) m_rb = m_prev;
                    if (P == 2 && r >= W + 1 && r <= 2*W && cfg_o !== m_frame[r-W-1]) m_verr_acc = 1;
                    if (r == LAT - 1) m_verr = m_verr_acc;
                    if (r == LAT) m_act = 0;
                end
            end
            if (idle && start) begin
                m_act = 1; m_t0 = cyc; m_frame = frame; m_prev = chain;
                m_abd = 0; m_verr = 0; m_verr_acc = 0;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        int r;
        bit e_en, e_i;
        r = cyc - m_t0;
        e_en = m_act && r >= 1 && r <= P*W;
        e_i  = e_en ? m_frame[(r-1) % W] : 1'b0;
        chk("cfg_en", cfg_en, e_en);
        chk("cfg_i", cfg_i, e_i);
        chk("busy", busy, m_act && r >= 1 && r <= LAT - 1);
        chk("done", done, m_act && r == LAT);
        chk("aborted", aborted, m_abd);
        chk("readback", readback, m_rb);
`ifdef CIPHER_CFG_LOADER_VERIFY_EN
        chk("verify_err", verify_err, m_verr);
`endif
    end

    task automatic run_load(input logic [W-1:0] f, input int abort_at, input int rst_at,
                            input bit spam, output int lat, output int en_n);
        lat = -1;
        en_n = 0;
        frame = f;
        start = 1'b1;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            frame = rnd_frame();
            if (cfg_en) en_n++;
            if (done) begin
                lat = k;
                break;
            end
            if (k == abort_at) abort = 1'b1;
            if (spam && busy && $urandom_range(3, 0) == 0) start = 1'b1;
            if (k == rst_at) begin
                #2 rst = 1'b0;
                #1;
                chk("async_rst_cfg_en", cfg_en, 1'b0);
                chk("async_rst_busy", busy, 1'b0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] pat, a, b, c, d, e, g, exp_rb;
        int lat, en_n;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cfg_en", cfg_en, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_readback", readback, '0);
        rst = 1'b1;
        @(negedge clk);

        pat = W'({25{8'h5A}});
        run_load(pat, 0, 0, 0, lat, en_n);
        chki("basic_latency", lat, LAT);
        chki("basic_en_cycles", en_n, P*W);
        chk("basic_readback", readback, {W{1'b1}});
        chk("basic_chain", chain, pat);

        a = rnd_frame();
        b = rnd_frame();
        run_load(a, 0, 0, 1, lat, en_n);
        chki("b2b_a_latency", lat, LAT);
        run_load(b, 0, 0, 1, lat, en_n);
        chki("b2b_b_latency", lat, LAT);
        chk("b2b_readback", readback, a);
        chk("b2b_chain", chain, b);

        c = rnd_frame();
        run_load(c, 101, 0, 0, lat, en_n);
        chki("abort_no_done", lat, -1);
        chk("abort_sticky", aborted, 1'b1);
        chk("abort_readback_kept", readback, a);
        exp_rb = {c[100:0], b[W-1:101]};
        d = rnd_frame();
        run_load(d, 0, 0, 0, lat, en_n);
        chki("after_abort_latency", lat, LAT);
        chk("after_abort_cleared", aborted, 1'b0);
        chk("after_abort_readback", readback, exp_rb);

        e = rnd_frame();
        run_load(e, 0, 51, 0, lat, en_n);
        exp_rb = {e[49:0], d[W-1:50]};
        g = rnd_frame();
        run_load(g, 0, 0, 0, lat, en_n);
        chki("after_rst_latency", lat, LAT);
        chk("after_rst_readback", readback, exp_rb);
        chk("after_rst_chain", chain, g);

        g = rnd_frame();
        frame = g;
        start0 = 1'b1;
        lat = -1;
        en_n = 0;
        for (int k = 1; k <= LAT0 + 20; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (cfg_en0) en_n++;
            if (done0) begin
                lat = k;
                break;
            end
        end
        chki("gap0_latency", lat, LAT0);
        chki("gap0_en_cycles", en_n, P*W);
        chk("gap0_readback", readback0, {W{1'b1}});
        chk("gap0_chain", chain0, g);

`ifdef CIPHER_CFG_LOADER_VERIFY_EN
        flip7 = 1'b1;
        run_load(rnd_frame(), 0, 0, 0, lat, en_n);
        chk("verify_flip_err", verify_err, 1'b1);
        flip7 = 1'b0;
        run_load(rnd_frame(), 0, 0, 0, lat, en_n);
        chk("verify_clean_err", verify_err, 1'b0);
        chki("verify_en_cycles", en_n, 2*W);
`endif

        for (int i = 0; i < 4; i++) begin
            run_load(rnd_frame(), ($urandom_range(1, 0) != 0) ? $urandom_range(LAT, 1) : 0,
                     0, 1, lat, en_n);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
